// File: rtl/calc_mem_pkg.sv
// Shared definitions for the calculator memory bank: op codes, word width, FSM encoding, BCD helpers.
// The ACC state exists only when MEM_ACCUM_EN is defined.
package calc_mem_pkg;

  localparam int unsigned BCD_WORD_W = 13;

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_STORE    = 2'b01;
  localparam logic [1:0] OP_RETRIEVE = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
`ifdef MEM_ACCUM_EN
  localparam logic [2:0] S_ACC   = 3'd4;
`endif

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // The sign bit is not part of the digit check.
  function automatic logic is_bcd_magnitude(input logic [BCD_WORD_W-1:0] w);
    return is_bcd_digit(w[11:8]) && is_bcd_digit(w[7:4]) && is_bcd_digit(w[3:0]);
  endfunction

endpackage

// File: rtl/bcd_addsub3.sv
// Combinational 3-digit sign-magnitude BCD adder/subtractor with saturation flag.
// Built only when MEM_ACCUM_EN is defined.
`ifdef MEM_ACCUM_EN
module bcd_addsub3
  import calc_mem_pkg::*;
(
  input  logic [BCD_WORD_W-1:0] a,
  input  logic [BCD_WORD_W-1:0] b,
  output logic [BCD_WORD_W-1:0] sum,
  output logic                  ovf
);

  logic [11:0] addMag;
  logic [11:0] subMag;
  logic [11:0] bigMag;
  logic [11:0] smallMag;
  logic        aBig;
  logic        addCarry;
  logic        c;
  logic [4:0]  t;

  always_comb begin
    sum      = '0;
    ovf      = 1'b0;
    addMag   = '0;
    subMag   = '0;
    addCarry = 1'b0;
    c        = 1'b0;
    t        = '0;
    // Packed valid BCD orders the same as its binary value.
    aBig     = a[11:0] >= b[11:0];
    bigMag   = aBig ? a[11:0] : b[11:0];
    smallMag = aBig ? b[11:0] : a[11:0];

    for (int unsigned i = 0; i < 3; i++) begin
      t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (t > 5'd9) begin
        addMag[4*i +: 4] = 4'(t - 5'd10);
        c = 1'b1;
      end else begin
        addMag[4*i +: 4] = t[3:0];
        c = 1'b0;
      end
    end
    addCarry = c;

    c = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      t = {1'b0, bigMag[4*i +: 4]} - {1'b0, smallMag[4*i +: 4]} - {4'b0, c};
      if (t[4]) begin
        subMag[4*i +: 4] = 4'(t + 5'd10);
        c = 1'b1;
      end else begin
        subMag[4*i +: 4] = t[3:0];
        c = 1'b0;
      end
    end

    if (a[12] == b[12]) begin
      if (addCarry) begin
        sum = {a[12], 12'h999};
        ovf = 1'b1;
      end else begin
        sum = {a[12], addMag};
      end
    end else begin
      sum = {aBig ? a[12] : b[12], subMag};
    end

    if (sum[11:0] == 12'h000) sum[12] = 1'b0;
  end

endmodule
`endif

// File: rtl/calc_memory_bank.sv
// Calculator memory bank: NUM_SLOTS signed-BCD words served over valid/ready request/response channels.
// Define MEM_ACCUM_EN to turn op 00 into M+ (saturating BCD accumulate, one extra cycle).
module calc_memory_bank
  import calc_mem_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [SLOT_W-1:0]     req_slot,
  input  logic [BCD_WORD_W-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BCD_WORD_W-1:0] rsp_data,
  output logic                  rsp_err
);

  logic [2:0]            state;
  logic [1:0]            opQ;
  logic [SLOT_W-1:0]     slotQ;
  logic [BCD_WORD_W-1:0] dataQ;
  logic                  errQ;
  logic [BCD_WORD_W-1:0] rspDataQ;
  logic                  rspErrQ;
  logic [BCD_WORD_W-1:0] slots [NUM_SLOTS];

  logic                  inRange;
  logic [BCD_WORD_W-1:0] curSlot;
  logic                  checkErr;
  logic                  needDigits;
  logic [BCD_WORD_W-1:0] storeVal;
  logic                  wrEn;
  logic [BCD_WORD_W-1:0] wrData;

`ifdef MEM_ACCUM_EN
  logic [BCD_WORD_W-1:0] accSum;
  logic                  accOvf;

  bcd_addsub3 uAddSub (
    .a   (curSlot),
    .b   (dataQ),
    .sum (accSum),
    .ovf (accOvf)
  );
`endif

  // Range check and read mux share one loop so out-of-range indices never touch the array.
  always_comb begin
    inRange = 1'b0;
    curSlot = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slotQ == SLOT_W'(i)) begin
        inRange = 1'b1;
        curSlot = slots[i];
      end
    end
  end

  always_comb begin
    needDigits = (opQ == OP_STORE);
`ifdef MEM_ACCUM_EN
    if (opQ == OP_NOP) needDigits = 1'b1;
`endif
    checkErr = !inRange || (needDigits && !is_bcd_magnitude(dataQ));
    storeVal = (dataQ[11:0] == 12'h000) ? '0 : dataQ;
  end

  always_comb begin
    wrEn   = 1'b0;
    wrData = '0;
    if (state == S_EXEC && !errQ) begin
      if (opQ == OP_STORE) begin
        wrEn   = 1'b1;
        wrData = storeVal;
      end else if (opQ == OP_CLEAR) begin
        wrEn   = 1'b1;
        wrData = '0;
      end
    end
`ifdef MEM_ACCUM_EN
    if (state == S_ACC) begin
      wrEn   = 1'b1;
      wrData = accSum;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (wrEn && slotQ == SLOT_W'(i)) slots[i] <= wrData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      opQ      <= OP_NOP;
      slotQ    <= '0;
      dataQ    <= '0;
      errQ     <= 1'b0;
      rspDataQ <= '0;
      rspErrQ  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            opQ   <= req_op;
            slotQ <= req_slot;
            dataQ <= req_data;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          errQ  <= checkErr;
          state <= S_EXEC;
        end
        S_EXEC: begin
          rspErrQ  <= errQ;
          rspDataQ <= wrEn ? wrData : (errQ ? '0 : curSlot);
`ifdef MEM_ACCUM_EN
          if (!errQ && opQ == OP_NOP) begin
            state <= S_ACC;
          end else begin
            state <= S_RESP;
          end
`else
          state <= S_RESP;
`endif
        end
`ifdef MEM_ACCUM_EN
        S_ACC: begin
          rspDataQ <= accSum;
          rspErrQ  <= accOvf;
          state    <= S_RESP;
        end
`endif
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = rst_n && (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = rspDataQ;
  assign rsp_err   = rspErrQ;

endmodule

// File: tb/tb_calc_memory_bank.sv
// Self-checking bench for calc_memory_bank: directed table, hand sequences and random traffic vs. an integer model.
module tb_calc_memory_bank;
  import calc_mem_pkg::*;

`ifdef MEM_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_slot;
  logic [12:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [12:0] rsp_data;
  logic        rsp_err;
  logic        req_ready3;
  logic        rsp_valid3;
  logic [12:0] rsp_data3;
  logic        rsp_err3;

  int checks = 0;
  int errors = 0;
  int mem[4];

  calc_memory_bank #(.NUM_SLOTS(4), .SLOT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_slot(req_slot), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Three-slot instance sharing the inputs, so slot 3 is out of range for it.
  calc_memory_bank #(.NUM_SLOTS(3), .SLOT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_op(req_op), .req_slot(req_slot), .req_data(req_data),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .rsp_err(rsp_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  slot;
    logic [12:0] data;
    int          hold;
    logic [12:0] expData;
    logic        expErr;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int toVal(input logic [12:0] w);
    int m;
    m = int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
    return w[12] ? -m : m;
  endfunction

  function automatic logic [12:0] toWord(input int v);
    int a;
    logic [12:0] w;
    a = (v < 0) ? -v : v;
    w[12]   = (v < 0);
    w[11:8] = 4'(a / 100);
    w[7:4]  = 4'((a / 10) % 10);
    w[3:0]  = 4'(a % 10);
    return w;
  endfunction

  function automatic bit digitsOk(input logic [12:0] w);
    for (int k = 0; k < 3; k++) if (w[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Integer-valued reference: the bank as four signed numbers in [-999, 999].
  task automatic modelOp(input logic [1:0] op, input int slot, input logic [12:0] data,
                         output logic [12:0] eData, output logic eErr, output int eLat);
    int s;
    eData = '0;
    eErr  = 1'b0;
    eLat  = 3;
    if (slot >= 4 || ((op == OP_STORE || (ACCUM && op == OP_NOP)) && !digitsOk(data))) begin
      eErr = 1'b1;
      return;
    end
    case (op)
      OP_STORE: mem[slot] = toVal(data);
      OP_CLEAR: mem[slot] = 0;
      OP_NOP: begin
        if (ACCUM) begin
          eLat = 4;
          s = mem[slot] + toVal(data);
          if (s > 999) begin s = 999; eErr = 1'b1; end
          else if (s < -999) begin s = -999; eErr = 1'b1; end
          mem[slot] = s;
        end
      end
      default: ;
    endcase
    eData = toWord(mem[slot]);
  endtask

  task automatic runTxn(input logic [1:0] op, input logic [1:0] slot, input logic [12:0] data,
                        input int hold, input logic [12:0] expData, input logic expErr, input int expLat,
                        input bit chk3, input logic [12:0] exp3Data, input logic exp3Err);
    int w;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_slot  = slot;
    req_data  = data;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_slot  = 2'($urandom);
    req_data  = 13'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    chk("latency", lat, expLat);
    chk("rsp_data", {19'b0, rsp_data}, {19'b0, expData});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, expErr});
    chk("rdy_busy", {31'b0, req_ready}, 32'd0);
    if (chk3) begin
      chk("d3_valid", {31'b0, rsp_valid3}, 32'd1);
      chk("d3_data", {19'b0, rsp_data3}, {19'b0, exp3Data});
      chk("d3_err", {31'b0, rsp_err3}, {31'b0, exp3Err});
    end
    for (int h = 0; h < hold; h++) begin
      req_data = 13'($urandom);
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_data", {19'b0, rsp_data}, {19'b0, expData});
      chk("hold_err", {31'b0, rsp_err}, {31'b0, expErr});
      chk("hold_rdy", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_rdy", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic applyConst(input logic [1:0] op, input logic [1:0] slot, input logic [12:0] data,
                            input int hold, input logic [12:0] expData, input logic expErr,
                            input bit chk3, input logic [12:0] exp3Data, input logic exp3Err);
    logic [12:0] md;
    logic        me;
    int          ml;
    modelOp(op, int'(slot), data, md, me, ml);
    runTxn(op, slot, data, hold, expData, expErr, ml, chk3, exp3Data, exp3Err);
  endtask

  task automatic applyModel(input logic [1:0] op, input logic [1:0] slot, input logic [12:0] data, input int hold);
    logic [12:0] md;
    logic        me;
    int          ml;
    modelOp(op, int'(slot), data, md, me, ml);
    runTxn(op, slot, data, hold, md, me, ml, 1'b0, '0, 1'b0);
  endtask

  task automatic checkResetOutputs();
    chk("rst_rdy", {31'b0, req_ready}, 32'd0);
    chk("rst_rdy3", {31'b0, req_ready3}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_data", {19'b0, rsp_data}, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    logic [12:0] rd;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_slot  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 0;

    tbl[0]  = '{OP_RETRIEVE, 2'd2, 13'h0000, 0, 13'h0000, 1'b0};
    tbl[1]  = '{OP_STORE,    2'd1, 13'h1305, 0, 13'h1305, 1'b0};
    tbl[2]  = '{OP_RETRIEVE, 2'd1, 13'h0777, 0, 13'h1305, 1'b0};
    tbl[3]  = '{OP_RETRIEVE, 2'd0, 13'h0000, 0, 13'h0000, 1'b0};
    tbl[4]  = '{OP_RETRIEVE, 2'd3, 13'h0000, 0, 13'h0000, 1'b0};
    tbl[5]  = '{OP_STORE,    2'd1, 13'h0A05, 0, 13'h0000, 1'b1};
    tbl[6]  = '{OP_RETRIEVE, 2'd1, 13'h0000, 0, 13'h1305, 1'b0};
    tbl[7]  = '{OP_STORE,    2'd0, 13'h0042, 5, 13'h0042, 1'b0};
    tbl[8]  = '{OP_CLEAR,    2'd0, 13'h0123, 0, 13'h0000, 1'b0};
    tbl[9]  = '{OP_RETRIEVE, 2'd0, 13'h0000, 0, 13'h0000, 1'b0};
    tbl[10] = '{OP_STORE,    2'd2, 13'h1000, 0, 13'h0000, 1'b0};
    tbl[11] = '{OP_RETRIEVE, 2'd2, 13'h0000, 2, 13'h0000, 1'b0};
    tbl[12] = '{OP_NOP,      2'd1, 13'h0000, 0, 13'h1305, 1'b0};
    tbl[13] = '{OP_STORE,    2'd0, 13'h0999, 0, 13'h0999, 1'b0};
    tbl[14] = '{OP_STORE,    2'd0, 13'h10F0, 1, 13'h0000, 1'b1};

    #1;
    checkResetOutputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 15; i++)
      applyConst(tbl[i].op, tbl[i].slot, tbl[i].data, tbl[i].hold, tbl[i].expData, tbl[i].expErr,
                 1'b0, '0, 1'b0);

    // Slot 3 is valid for the 4-slot bank but out of range for the 3-slot one.
    applyConst(OP_STORE, 2'd3, 13'h0123, 0, 13'h0123, 1'b0, 1'b1, 13'h0000, 1'b1);
    applyConst(OP_RETRIEVE, 2'd3, 13'h0000, 0, 13'h0123, 1'b0, 1'b1, 13'h0000, 1'b1);
    applyConst(OP_RETRIEVE, 2'd1, 13'h0000, 0, 13'h1305, 1'b0, 1'b1, 13'h1305, 1'b0);

`ifdef MEM_ACCUM_EN
    applyConst(OP_STORE, 2'd0, 13'h0950, 0, 13'h0950, 1'b0, 1'b0, '0, 1'b0);
    applyConst(OP_NOP,   2'd0, 13'h0075, 0, 13'h0999, 1'b1, 1'b0, '0, 1'b0);
    applyConst(OP_STORE, 2'd1, 13'h0020, 0, 13'h0020, 1'b0, 1'b0, '0, 1'b0);
    applyConst(OP_NOP,   2'd1, 13'h1020, 0, 13'h0000, 1'b0, 1'b0, '0, 1'b0);
    applyConst(OP_STORE, 2'd2, 13'h1500, 0, 13'h1500, 1'b0, 1'b0, '0, 1'b0);
    applyConst(OP_NOP,   2'd2, 13'h1600, 1, 13'h1999, 1'b1, 1'b0, '0, 1'b0);
    applyConst(OP_NOP,   2'd2, 13'h0A00, 0, 13'h0000, 1'b1, 1'b0, '0, 1'b0);
    applyConst(OP_NOP,   2'd2, 13'h0004, 0, 13'h1995, 1'b0, 1'b0, '0, 1'b0);
`endif

    // Reset during EXEC: no response, all slots cleared.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_STORE;
    req_slot  = 2'd2;
    req_data  = 13'h0123;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    for (int i = 0; i < 4; i++) mem[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_rdy", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
    end
    for (int i = 0; i < 4; i++) applyModel(OP_RETRIEVE, 2'(i), 13'h0000, 0);

    for (int n = 0; n < 150; n++) begin
      rd[12]   = 1'($urandom_range(0, 1));
      rd[11:8] = 4'($urandom_range(0, 9));
      rd[7:4]  = 4'($urandom_range(0, 9));
      rd[3:0]  = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) rd[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
      applyModel(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rd, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
